// File: rtl/mcb_read_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcb_read_ctrl_pkg
// Brief    : Shared state encodings and MCB command constants for the
//            instruction-cache fill controller.
// Revision : 1.0 - initial release
// ============================================================================
package mcb_read_ctrl_pkg;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_cmd   = 2'd1;
    localparam logic [1:0] c_st_read  = 2'd2;
    localparam logic [1:0] c_st_drain = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = c_st_idle,
        S_CMD   = c_st_cmd,
        S_READ  = c_st_read,
        S_DRAIN = c_st_drain
    } state_t;

    localparam logic [2:0] MCB_CMD_READ = 3'b001;

    localparam int c_default_burst_words = 8;

endpackage
`default_nettype wire

// File: rtl/mcb_read_ctrl_stall_timer.sv
`default_nettype none
// ============================================================================
// Module   : stall_timer
// Brief    : Counts consecutive stalled cycles; expired fires on the LIMIT-th.
//            Present only when MCB_READ_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef MCB_READ_TIMEOUT_EN
module stall_timer #(
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    localparam int c_cnt_w = $clog2(LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(LIMIT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    assign expired = tick && (r_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || expired) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

endmodule
`endif
`default_nettype wire

// File: rtl/mcb_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mcb_read_ctrl
// Brief    : Issues one MCB read burst per cache fill request and streams the
//            returned words. Optional stall timeout: MCB_READ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mcb_read_ctrl
    import mcb_read_ctrl_pkg::*;
#(
    parameter int BURST_WORDS    = c_default_burst_words,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [29:0] req_addr,
    output logic        word_valid,
    output logic [31:0] word_data,
    output logic [5:0]  word_index,
    output logic        fill_done,
    output logic        fill_error,
    output logic        mem_cmd_en,
    output logic [2:0]  mem_cmd_instr,
    output logic [5:0]  mem_cmd_bl,
    output logic [29:0] mem_cmd_byte_addr,
    input  logic        mem_cmd_full,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rd_empty,
    input  logic        mem_rd_overflow,
    input  logic        mem_rd_error
);
    localparam logic [6:0] c_burst = 7'(BURST_WORDS);
    localparam logic [6:0] c_last  = 7'(BURST_WORDS - 1);
    localparam logic [5:0] c_bl    = 6'(BURST_WORDS - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [29:0] r_addr;
    logic [6:0]  r_count;
    logic        r_word_valid;
    logic        r_fill_done;
    logic        r_fill_error;
    logic [31:0] r_word_data;
    logic [5:0]  r_word_index;

    logic        w_pop;
    logic        w_fault;
    logic        w_timeout;
    logic        w_accept_req;
    logic        w_word_valid_nxt;
    logic        w_fill_done_nxt;
    logic        w_fill_error_nxt;

    assign w_pop        = ((r_state == S_READ) || (r_state == S_DRAIN)) && !mem_rd_empty;
    assign w_fault      = mem_rd_error || mem_rd_overflow;
    assign w_accept_req = (r_state == S_IDLE) && req_valid;

`ifdef MCB_READ_TIMEOUT_EN
    logic w_stall;
    assign w_stall = (r_state == S_READ) && mem_rd_empty;

    stall_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!w_stall),
        .tick   (w_stall),
        .expired(w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        req_ready        = 1'b0;
        mem_cmd_en       = 1'b0;
        w_word_valid_nxt = 1'b0;
        w_fill_done_nxt  = 1'b0;
        w_fill_error_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                if (!mem_cmd_full) begin
                    mem_cmd_en  = 1'b1;
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                // A fault outranks completion even on the final word.
                if (w_fault) begin
                    w_fill_error_nxt = 1'b1;
                    w_state_nxt      = S_DRAIN;
                end else if (w_timeout) begin
                    w_fill_error_nxt = 1'b1;
                    w_state_nxt      = S_IDLE;
                end else if (w_pop) begin
                    w_word_valid_nxt = 1'b1;
                    if (r_count == c_last) begin
                        w_fill_done_nxt = 1'b1;
                        w_state_nxt     = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (mem_rd_empty && ((r_count >= c_burst) || !mem_rd_error)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The counter keeps advancing through DRAIN so it also tracks the words still owed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_count      <= '0;
            r_word_valid <= 1'b0;
            r_fill_done  <= 1'b0;
            r_fill_error <= 1'b0;
            r_word_data  <= '0;
            r_word_index <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_word_valid <= w_word_valid_nxt;
            r_fill_done  <= w_fill_done_nxt;
            r_fill_error <= w_fill_error_nxt;
            if (w_accept_req) begin
                r_addr  <= req_addr & ~30'h3;
                r_count <= '0;
            end else if (w_pop && (r_count < c_burst)) begin
                r_count <= r_count + 7'd1;
            end
            if (w_word_valid_nxt) begin
                r_word_data  <= mem_rd_data;
                r_word_index <= r_count[5:0];
            end
        end
    end

    assign mem_rd_en         = w_pop;
    assign mem_cmd_instr     = MCB_CMD_READ;
    assign mem_cmd_bl        = c_bl;
    assign mem_cmd_byte_addr = r_addr;
    assign word_valid        = r_word_valid;
    assign word_data         = r_word_data;
    assign word_index        = r_word_index;
    assign fill_done         = r_fill_done;
    assign fill_error        = r_fill_error;

endmodule
`default_nettype wire

// File: tb/tb_mcb_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcb_read_ctrl
// Brief    : Self-checking bench for mcb_read_ctrl with an MCB port emulator
//            and a transaction-level expectation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcb_read_ctrl;
    localparam int BURST = 8;
    localparam int TO    = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [29:0] req_addr = '0;
    logic        word_valid;
    logic [31:0] word_data;
    logic [5:0]  word_index;
    logic        fill_done;
    logic        fill_error;
    logic        mem_cmd_en;
    logic [2:0]  mem_cmd_instr;
    logic [5:0]  mem_cmd_bl;
    logic [29:0] mem_cmd_byte_addr;
    logic        mem_cmd_full = 1'b0;
    logic        mem_rd_en;
    logic [31:0] mem_rd_data = '0;
    logic        mem_rd_empty = 1'b1;
    logic        mem_rd_overflow = 1'b0;
    logic        mem_rd_error = 1'b0;

    always #5 clk = ~clk;

    mcb_read_ctrl #(
        .BURST_WORDS   (BURST),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .word_valid       (word_valid),
        .word_data        (word_data),
        .word_index       (word_index),
        .fill_done        (fill_done),
        .fill_error       (fill_error),
        .mem_cmd_en       (mem_cmd_en),
        .mem_cmd_instr    (mem_cmd_instr),
        .mem_cmd_bl       (mem_cmd_bl),
        .mem_cmd_byte_addr(mem_cmd_byte_addr),
        .mem_cmd_full     (mem_cmd_full),
        .mem_rd_en        (mem_rd_en),
        .mem_rd_data      (mem_rd_data),
        .mem_rd_empty     (mem_rd_empty),
        .mem_rd_overflow  (mem_rd_overflow),
        .mem_rd_error     (mem_rd_error)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- MCB port emulator ----------------
    logic [31:0] q[$];
    int  popped = 0;
    bit  pop_pending = 0, cmd_pending = 0;
    int  err_left = 0;
    bit  err_fired = 1, ovf_fired = 1, tog = 0;
    int  g_err_at = -1, g_err_len = 2, g_ovf_at = -1, g_gap_pct = 0;
    bit  g_toggle = 0, g_no_data = 0, g_random = 0;

    always @(negedge clk) begin
        pop_pending = mem_rd_en;
        cmd_pending = mem_cmd_en;
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            q.delete();
            popped    = 0;
            err_left  = 0;
            err_fired = 1;
            ovf_fired = 1;
            mem_rd_overflow = 1'b0;
        end else begin
            if (pop_pending && q.size() > 0) begin
                void'(q.pop_front());
                popped++;
            end
            if (cmd_pending) begin
                q.delete();
                for (int i = 0; i < BURST; i++) q.push_back($urandom);
                popped = 0; err_left = 0; err_fired = 0; ovf_fired = 0;
                if (g_random) begin
                    g_gap_pct = int'($urandom_range(0, 60));
                    g_err_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BURST-1)) : -1;
                    g_err_len = int'($urandom_range(1, 3));
                    g_ovf_at  = (g_err_at < 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, BURST-1)) : -1;
                end
            end
            if (err_left > 0) err_left--;
            if (!err_fired && g_err_at >= 0 && popped == g_err_at) begin
                err_fired = 1;
                err_left  = g_err_len;
            end
            mem_rd_overflow = (!ovf_fired && g_ovf_at >= 0 && popped == g_ovf_at);
            if (mem_rd_overflow) ovf_fired = 1;
        end
        mem_rd_error = (err_left > 0);
        tog = ~tog;
        mem_rd_empty = (q.size() == 0) || g_no_data || (g_toggle && tog) ||
                       (int'($urandom_range(0, 99)) < g_gap_pct);
        mem_rd_data = (q.size() > 0) ? q[0] : 32'hDEAD_BEEF;
    end

    // ---------------- expectation model + compare ----------------
    bit          m_busy = 0, m_cmd = 0, m_drain = 0;
    int          m_got = 0, m_stall = 0;
    logic [29:0] m_addr = '0;
    logic        e_wv = 0, e_done = 0, e_err = 0;
    logic [31:0] e_data = '0;
    logic [5:0]  e_idx = '0;

    int          n_cmd, n_wv, n_done, n_err, cyc, cmd_cyc, err_cyc;
    bit          order_bad, err_ready;
    logic [29:0] cap_addr;
    logic [5:0]  cap_bl, done_idx;

    task automatic clear_mon();
        n_cmd = 0; n_wv = 0; n_done = 0; n_err = 0; order_bad = 0;
        cmd_cyc = 0; err_cyc = 0; err_ready = 0;
        cap_addr = '0; cap_bl = '0; done_idx = '0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 1);
            chk("rst_word_valid", word_valid, 0);
            chk("rst_fill_done", fill_done, 0);
            chk("rst_fill_error", fill_error, 0);
            chk("rst_mem_cmd_en", mem_cmd_en, 0);
            chk("rst_mem_rd_en", mem_rd_en, 0);
            m_busy = 0; m_cmd = 0; m_drain = 0; m_got = 0; m_stall = 0;
            e_wv = 0; e_done = 0; e_err = 0;
        end else begin
            chk("req_ready", req_ready, !m_busy);
            chk("mem_cmd_en", mem_cmd_en, m_busy && m_cmd && !mem_cmd_full);
            chk("mem_rd_en", mem_rd_en, m_busy && !m_cmd && !mem_rd_empty);
            chk("word_valid", word_valid, e_wv);
            chk("fill_done", fill_done, e_done);
            chk("fill_error", fill_error, e_err);
            if (e_wv) begin
                chk("word_data", word_data, e_data);
                chk("word_index", word_index, e_idx);
            end
            if (m_busy) begin
                chk("cmd_addr", mem_cmd_byte_addr, m_addr);
                chk("cmd_bl", mem_cmd_bl, BURST - 1);
                chk("cmd_instr", mem_cmd_instr, 3'b001);
            end
            cyc++;
            if (mem_cmd_en) begin
                n_cmd++; cmd_cyc = cyc;
                cap_addr = mem_cmd_byte_addr; cap_bl = mem_cmd_bl;
            end
            if (word_valid) begin
                if (word_index != 6'(n_wv)) order_bad = 1;
                n_wv++;
            end
            if (fill_done) begin n_done++; done_idx = word_index; end
            if (fill_error) begin n_err++; err_cyc = cyc; err_ready = req_ready; end

            // Next-cycle expectations from the burst rules.
            e_wv = 0; e_done = 0; e_err = 0;
            if (!m_busy) begin
                if (req_valid) begin
                    m_busy = 1; m_cmd = 1; m_drain = 0; m_got = 0; m_stall = 0;
                    m_addr = {req_addr[29:2], 2'b00};
                end
            end else if (m_cmd) begin
                if (!mem_cmd_full) m_cmd = 0;
            end else if (m_drain) begin
                if (!mem_rd_empty) begin
                    if (m_got < BURST) m_got++;
                end else if (m_got == BURST || !mem_rd_error) begin
                    m_busy = 0;
                end
            end else begin
                if (mem_rd_error || mem_rd_overflow) begin
                    e_err = 1; m_drain = 1;
                    if (!mem_rd_empty) m_got++;
                end else if (mem_rd_empty) begin
                    m_stall++;
`ifdef MCB_READ_TIMEOUT_EN
                    if (m_stall == TO) begin e_err = 1; m_busy = 0; end
`endif
                end else begin
                    m_stall = 0;
                    e_wv = 1; e_data = mem_rd_data; e_idx = 6'(m_got);
                    m_got++;
                    if (m_got == BURST) begin e_done = 1; m_busy = 0; end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [29:0] a);
        req_addr  = a;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_addr  = 30'($urandom);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        tick();
        while (!req_ready && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_bound"}, 32'(n < budget), 1);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        clear_mon();
        cyc = 0;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_req_ready", req_ready, 1);
        chk("reset_word_valid", word_valid, 0);
        chk("reset_fill_done", fill_done, 0);
        chk("reset_fill_error", fill_error, 0);
        chk("reset_mem_cmd_en", mem_cmd_en, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Clean burst with unaligned address.
        clear_mon();
        issue(30'h107);
        wait_idle("clean", 100);
        chk("clean_addr", cap_addr, 30'h104);
        chk("clean_bl", cap_bl, 7);
        chk("clean_cmd_pulses", n_cmd, 1);
        chk("clean_words", n_wv, 8);
        chk("clean_order", order_bad, 0);
        chk("clean_done", n_done, 1);
        chk("clean_done_idx", done_idx, 7);
        chk("clean_err", n_err, 0);

        // Command back-pressure for five cycles.
        clear_mon();
        mem_cmd_full = 1'b1;
        issue(30'h2000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", mem_cmd_en, 0);
            tick();
        end
        mem_cmd_full = 1'b0;
        @(negedge clk);
        chk("bp_pulse", mem_cmd_en, 1);
        tick();
        @(negedge clk);
        chk("bp_after", mem_cmd_en, 0);
        wait_idle("bp", 100);
        chk("bp_cmd_pulses", n_cmd, 1);
        chk("bp_words", n_wv, 8);
        chk("bp_done", n_done, 1);

        // Read data arriving every other cycle.
        g_toggle = 1;
        clear_mon();
        issue(30'h3F0);
        wait_idle("gap", 200);
        chk("gap_words", n_wv, 8);
        chk("gap_order", order_bad, 0);
        chk("gap_done", n_done, 1);
        g_toggle = 0;

        // Read error on word 3.
        g_err_at = 3; g_err_len = 2;
        clear_mon();
        issue(30'h500);
        wait_idle("err", 100);
        chk("err_words", n_wv, 3);
        chk("err_order", order_bad, 0);
        chk("err_pulses", n_err, 1);
        chk("err_done", n_done, 0);
        chk("err_ready", req_ready, 1);
        g_err_at = -1;

`ifdef MCB_READ_TIMEOUT_EN
        // No data ever arrives: stall limit must fire.
        g_no_data = 1;
        clear_mon();
        issue(30'h700);
        wait_idle("to", 100);
        chk("to_latency", err_cyc - cmd_cyc, 16);
        chk("to_ready", err_ready, 1);
        chk("to_pulses", n_err, 1);
        chk("to_words", n_wv, 0);
        g_no_data = 0;
`endif

        // Reset in the middle of a burst, then a fresh request.
        clear_mon();
        issue(30'h900);
        n = 0;
        while (n_wv < 5 && n < 50) begin
            tick();
            n++;
        end
        chk("rstmid_bound", 32'(n < 50), 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_word_valid", word_valid, 0);
        chk("rstmid_word_index", word_index, 0);
        chk("rstmid_fill_done", fill_done, 0);
        chk("rstmid_fill_error", fill_error, 0);
        chk("rstmid_mem_cmd_en", mem_cmd_en, 0);
        chk("rstmid_mem_rd_en", mem_rd_en, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clear_mon();
        issue(30'hA04);
        wait_idle("rstnew", 100);
        chk("rstnew_words", n_wv, 8);
        chk("rstnew_order", order_bad, 0);
        chk("rstnew_done", n_done, 1);
        chk("rstnew_err", n_err, 0);

        // Randomised traffic, including requests raised while busy.
        g_random = 1;
        for (int i = 0; i < 3000; i++) begin
            req_valid    = ($urandom_range(0, 3) == 0);
            req_addr     = 30'($urandom);
            mem_cmd_full = ($urandom_range(0, 3) == 0);
            tick();
        end
        req_valid    = 1'b0;
        mem_cmd_full = 1'b0;
        n = 0;
        while (!req_ready && n < 500) begin
            tick();
            n++;
        end
        chk("rand_settle_bound", 32'(n < 500), 1);
        g_random = 0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
